// File: rtl/cnt_rr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cnt_rr_sched                                           |
// | Description : Round-robin scheduler sharing one down-counting        |
// |               interval timer between N requesters. The winner owns   |
// |               the counter for its programmed length and receives a   |
// |               one-cycle done pulse on normal completion.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cnt_rr_sched #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N-1:0]                      req,
  input  logic [N*CW-1:0]                   len,
  output logic [N-1:0]                      grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] owner,
  output logic                              busy,
  output logic [CW-1:0]                     cnt,
  output logic [N-1:0]                      done
);

  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0]  c_one_n  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] c_one_cw = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [OW-1:0] c_last_rst = OW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [N-1:0]    r_grant, w_grant_nxt;
  logic [N-1:0]    r_done,  w_done_nxt;
  logic [OW-1:0]   r_owner, w_owner_nxt;
  logic [OW-1:0]   r_last,  w_last_nxt;
  logic            r_busy,  w_busy_nxt;
  logic [CW-1:0]   r_cnt,   w_cnt_nxt;

  logic            w_found;
  logic [OW-1:0]   w_win;
  logic [OW-1:0]   w_cand;
  int              w_sum;
  logic [CW-1:0]   w_len;
  logic [CW-1:0]   w_load;
  logic [N-1:0]    w_win_onehot;
  logic [N-1:0]    w_owner_onehot;

  // Round-robin search starting just after the last-served requester.
  // Scanning from the farthest candidate down lets the nearest one win.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    w_sum   = 0;
    for (int k = N; k >= 1; k--) begin
      w_sum = int'(r_last) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_cand = OW'(w_sum);
      if (req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // Winner's interval length; a zero length still runs for one cycle.
  always_comb begin
    w_len = '0;
    for (int i = 0; i < N; i++) begin
      if (w_win == OW'(i)) w_len = len[i*CW +: CW];
    end
    w_load       = (w_len == '0) ? c_one_cw : w_len;
    w_win_onehot = c_one_n << w_win;
  end

  // One-hot of the current owner, used for the completion pulse.
  always_comb begin
    w_owner_onehot = c_one_n << r_owner;
  end

  // Next-state and next-output logic for the scheduler FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_busy_nxt  = r_busy;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        if (w_found) begin
          w_state_nxt = COUNT;
          w_owner_nxt = w_win;
          w_last_nxt  = w_win;
          w_grant_nxt = w_win_onehot;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = w_load;
        end
      end
      COUNT: begin
        if (req[r_owner]) begin
          if (r_cnt > c_one_cw) begin
            w_cnt_nxt = r_cnt - c_one_cw;
          end else begin
            // Final counted cycle: release the counter and flag completion.
            w_cnt_nxt   = '0;
            w_grant_nxt = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = w_owner_onehot;
            w_state_nxt = DONE;
          end
        end else begin
          // Owner withdrew: release without a done pulse, keep the pointer.
          w_cnt_nxt   = '0;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_owner <= '0;
      r_last  <= c_last_rst;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign grant = r_grant;
  assign done  = r_done;
  assign owner = r_owner;
  assign busy  = r_busy;
  assign cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cnt_rr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_cnt_rr_sched                                        |
// | Description : Directed self-checking bench for cnt_rr_sched          |
// |               (N=4, CW=8).                                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_cnt_rr_sched;

  localparam int N  = 4;
  localparam int CW = 8;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*CW-1:0] len;
  logic [N-1:0]    grant;
  logic [1:0]      owner;
  logic            busy;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    done;

  int checks   = 0;
  int failures = 0;

  cnt_rr_sched #(.N(N), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .len   (len),
    .grant (grant),
    .owner (owner),
    .busy  (busy),
    .cnt   (cnt),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic b,
                           input logic [7:0] c, input logic [3:0] d);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".busy"},  32'(busy),  32'(b));
    check({tag, ".cnt"},   32'(cnt),   32'(c));
    check({tag, ".done"},  32'(done),  32'(d));
  endtask

  initial begin
    int order [5];
    logic [3:0] oh;
    order = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    req = 4'b1111;
    len = {8'd2, 8'd2, 8'd2, 8'd2};

    // Reset held two cycles with all requests asserted.
    step();
    check_all("rst1", 4'b0000, 1'b0, 8'd0, 4'b0000);
    step();
    check_all("rst2", 4'b0000, 1'b0, 8'd0, 4'b0000);
    check("rst2.owner", 32'(owner), 32'd0);
    rst = 1'b0;

    // Fairness: all held, len=2, order 0,1,2,3,0 with one done cycle between.
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << order[k];
      step();
      check_all($sformatf("rr%0d.load", k), oh, 1'b1, 8'd2, 4'b0000);
      check($sformatf("rr%0d.owner", k), 32'(owner), 32'(order[k]));
      step();
      check_all($sformatf("rr%0d.run", k), oh, 1'b1, 8'd1, 4'b0000);
      step();
      check_all($sformatf("rr%0d.done", k), 4'b0000, 1'b0, 8'd0, oh);
    end
    req = 4'b0000;
    step();
    check_all("rr.idle", 4'b0000, 1'b0, 8'd0, 4'b0000);

    // Single request on requester 2 with length 3.
    req = 4'b0100;
    len = {8'd2, 8'd3, 8'd2, 8'd2};
    step();
    check_all("single.c3", 4'b0100, 1'b1, 8'd3, 4'b0000);
    check("single.owner", 32'(owner), 32'd2);
    len = {8'd9, 8'd9, 8'd9, 8'd9};
    step();
    check_all("single.c2", 4'b0100, 1'b1, 8'd2, 4'b0000);
    step();
    check_all("single.c1", 4'b0100, 1'b1, 8'd1, 4'b0000);
    step();
    check_all("single.done", 4'b0000, 1'b0, 8'd0, 4'b0100);
    req = 4'b0000;
    step();
    check_all("single.idle", 4'b0000, 1'b0, 8'd0, 4'b0000);

    // Zero length runs for one cycle.
    req = 4'b0010;
    len = {8'd2, 8'd2, 8'd0, 8'd2};
    step();
    check_all("len0.run", 4'b0010, 1'b1, 8'd1, 4'b0000);
    step();
    check_all("len0.done", 4'b0000, 1'b0, 8'd0, 4'b0010);
    req = 4'b0000;
    step();
    check_all("len0.idle", 4'b0000, 1'b0, 8'd0, 4'b0000);

    // Abort: requester 3 with len 10 drops at cnt=6, requester 0 pending.
    req = 4'b1000;
    len = {8'd10, 8'd2, 8'd2, 8'd2};
    step();
    check_all("abort.c10", 4'b1000, 1'b1, 8'd10, 4'b0000);
    check("abort.owner", 32'(owner), 32'd3);
    step();
    step();
    step();
    step();
    check_all("abort.c6", 4'b1000, 1'b1, 8'd6, 4'b0000);
    req = 4'b0001;
    step();
    check_all("abort.drop", 4'b0000, 1'b0, 8'd0, 4'b0000);
    step();
    check_all("abort.next", 4'b0001, 1'b1, 8'd2, 4'b0000);
    check("abort.next.owner", 32'(owner), 32'd0);
    step();
    step();
    check_all("abort.next.done", 4'b0000, 1'b0, 8'd0, 4'b0001);

    // Reset mid-count at cnt=5, then requester 0 regains priority.
    req = 4'b0100;
    len = {8'd2, 8'd8, 8'd2, 8'd2};
    step();
    check_all("mrst.c8", 4'b0100, 1'b1, 8'd8, 4'b0000);
    step();
    step();
    step();
    check_all("mrst.c5", 4'b0100, 1'b1, 8'd5, 4'b0000);
    rst = 1'b1;
    req = 4'b1111;
    step();
    check_all("mrst.rst", 4'b0000, 1'b0, 8'd0, 4'b0000);
    check("mrst.owner", 32'(owner), 32'd0);
    rst = 1'b0;
    step();
    check_all("mrst.first", 4'b0001, 1'b1, 8'd2, 4'b0000);
    check("mrst.first.owner", 32'(owner), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
